i2s_dac_tx: RTL
===============

# i2s_dac_tx

I2S transmitter that streams stereo PCM samples out to the WM8731 audio codec DAC on `AUD_BCLK`, `AUD_DACLRCK` and `AUD_DACDAT`. The FPGA is bus master and generates bit clock and word clock from the 50 MHz system clock. A one-frame holding register decouples the upstream producer, which is the audio processing core behind the lightweight bus, from the serial frame timing. It is the playback-direction counterpart of the ADC capture path and sits between the audio core and the codec pins in the top level.

## Interface
Parameters:
- `SAMPLE_W`, default 16: PCM width per channel, two's complement. Legal range 8..31.
- `BCLK_HALF`, default 8: clk cycles per BCLK half-period. Must be ≥2. The default gives BCLK = 3.125 MHz and fs = 48.83 kHz.

Ports:
- `clk` in 1: 50 MHz system clock, the single clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `s_left` in SAMPLE_W: left sample.
- `s_right` in SAMPLE_W: right sample.
- `s_valid` in 1: the stereo pair is valid.
- `s_ready` out 1: holding register empty; the pair is accepted when valid and ready are both high.
- `underrun` out 1: one-clk pulse when a frame starts with no sample held.
- `aud_bclk` out 1: bit clock to the codec.
- `aud_daclrck` out 1: word clock; 0 = left, 1 = right.
- `aud_dacdat` out 1: serial data, MSB first.

## Operation
- Reset values, applied asynchronously:
  - `aud_bclk`, `aud_daclrck`, `aud_dacdat`, `underrun` = 0.
  - `s_ready` = 1.
  - Divider, bit counter, holding register and frame register cleared.
- Divider: `div_cnt` counts 0..BCLK_HALF-1. On the terminal count it wraps to 0 and toggles `aud_bclk`.
- Falling-edge event `fall`: the clk cycle in which `aud_bclk` toggles 1→0.
- Bit counter: `bit_cnt[5:0]` advances once per `fall` and wraps 63→0.
  - Slot index k = `bit_cnt[4:0]`.
  - `aud_daclrck` = `bit_cnt[5]`.
  - Frame = 64 BCLK = 2 slots of 32.
- Serial data, I2S format:
  - `aud_dacdat` for slot index k is `sample[SAMPLE_W-k]` for k in 1..SAMPLE_W, else 0.
  - The MSB therefore appears one BCLK after the LRCK edge, with zero padding after it.
  - The left slot uses frame-left; the right slot uses frame-right.
- All pin outputs change only on `fall` cycles. The codec samples on the BCLK rising edge.
- Holding register:
  - A transfer (`s_valid && s_ready`) loads {left, right}. `hold_full` is set and `s_ready` drops the next cycle.
- Frame load, on the `fall` cycle where `bit_cnt` wraps 63→0:
  - If `hold_full` is set: the frame register takes the holding contents and `hold_full` clears.
  - If `hold_full` is clear: the frame register is zeroed and `underrun` pulses for 1 clk.
- Simultaneous transfer and frame load while the holding register is empty:
  - The new pair goes into the holding register only.
  - The current frame plays zeros and `underrun` pulses.
  - The new pair plays in the next frame.
- A transfer while `hold_full` is set cannot occur, because `s_ready` is low.
- Reset asserted mid-frame: the frame is aborted, all outputs return to their reset values immediately, and the held sample is discarded.
- After reset release, the first frame plays zeros unless a sample is accepted before the first wrap.

## Timing
- BCLK period = 2·BCLK_HALF clk. The first `aud_bclk` rise occurs BCLK_HALF clk after reset release.
- Frame period = 128·BCLK_HALF clk, which is 1024 at the default.
- `s_ready` returns high the clk after the frame-load cycle.
- Latency: a sample accepted before a wrap has its left MSB on `aud_dacdat` at the next `fall` after that wrap, i.e. 2·BCLK_HALF clk after the wrap.
- `underrun` is registered and aligned to the frame-load cycle plus 1.
- Output-side throughput is one pair per frame. The upstream producer has a full frame minus one clk to present the next pair.

## Structure
- Package `i2s_pkg`:
  - `SLOT_BITS = 32`
  - `FRAME_BITS = 64`
  - Typedef `stereo_t` = struct {left, right} of `logic signed [SAMPLE_W-1:0]`. SAMPLE_W is passed as a package parameter default of 16.
- Sub-module `i2s_clk_gen`: divider plus bit counter. It outputs `aud_bclk`, `fall`, `bit_cnt` and `frame_start`. The same sub-module is reused by the capture side for slave-free operation.
- Top `i2s_dac_tx` contains the holding register, the frame register, the bit-select mux and the underrun logic.

## Test plan
- **Reset:** assert `reset_n`=0 mid-frame → all outputs are 0 and `s_ready`=1 within the same cycle, with no clk edge needed.
- **Single sample:** send left=16'hA5C3, right=16'h5A3C before the first wrap. Sample `aud_dacdat` on BCLK rise →
  - left slot bits 1..16 = A5C3 MSB-first;
  - right slot bits 1..16 = 5A3C;
  - bit 0 and bits 17..31 = 0;
  - LRCK low in the left slot and high in the right slot.
- **Underrun:** send no sample → each wrap emits an all-zero frame and one 1-clk `underrun` pulse per frame.
- **Backpressure:** hold `s_valid` high continuously with incrementing data → exactly one transfer per 1024 clk, no pair skipped or repeated, and `s_ready` high for exactly 1 clk per frame window after each load.
- **Simultaneous event:** assert the transfer in the same cycle as a wrap with the holding register empty → that frame is zeros with `underrun`, and the next frame carries the pair.
- **Parameters:** run with SAMPLE_W=24 and BCLK_HALF=2 → BCLK period 4 clk, frame 256 clk, and 24 data bits at slot positions 1..24.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and payload types for the I2S playback and capture paths.
package i2s_pkg;

   localparam int unsigned SLOT_BITS    = 32;
   localparam int unsigned FRAME_BITS   = 64;
   localparam int unsigned BIT_CNT_W    = $clog2(FRAME_BITS);
   localparam int unsigned SLOT_IDX_W   = $clog2(SLOT_BITS);
   localparam int unsigned SAMPLE_W_DEF = 16;

   // Stereo pair at the default sample width.
   typedef struct packed {
      logic signed [SAMPLE_W_DEF-1:0] left;
      logic signed [SAMPLE_W_DEF-1:0] right;
   } stereo_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider and frame bit counter for an I2S master.
// Ports:
//   clk, reset_n       : system clock, async active-low reset
//   o_bclk             : bit clock (registered), first rise BCLK_HALF clk after reset
//   o_fall_c           : high in the clk cycle where o_bclk toggles 1->0
//   o_frame_start_c    : high on the fall where o_bit_cnt wraps 63->0
//   o_bit_cnt          : position within the 64-bit frame, advances on each fall
module i2s_clk_gen
   import i2s_pkg::*;
#(
   parameter int unsigned BCLK_HALF = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   output logic                 o_bclk,
   output logic                 o_fall_c,
   output logic                 o_frame_start_c,
   output logic [BIT_CNT_W-1:0] o_bit_cnt
);

   localparam int unsigned DIV_W = $clog2(BCLK_HALF);

   logic [DIV_W-1:0]     r_div_cnt;
   logic                 r_bclk;
   logic [BIT_CNT_W-1:0] r_bit_cnt;
   logic                 w_tc;

   // Terminal count of the half-period divider.
   assign w_tc            = (r_div_cnt == DIV_W'(BCLK_HALF - 1));
   assign o_fall_c        = w_tc & r_bclk;
   assign o_frame_start_c = o_fall_c & (r_bit_cnt == '1);
   assign o_bclk          = r_bclk;
   assign o_bit_cnt       = r_bit_cnt;

   // Divider, bit clock and bit counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div_cnt <= '0;
         r_bclk    <= 1'b0;
         r_bit_cnt <= '0;
      end else begin
         if (w_tc) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
         end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end
         if (o_fall_c) begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter to the codec DAC: one-pair holding register, frame register,
// MSB-first serializer with one BCLK of delay after LRCK, and underrun flag.
// Ports:
//   clk, reset_n                : system clock, async active-low reset
//   s_left/s_right/s_valid      : stereo pair from the audio core
//   s_ready                     : holding register empty
//   underrun                    : 1-clk pulse when a frame starts with nothing held
//   aud_bclk/aud_daclrck/aud_dacdat : codec pins, change only on BCLK falls
module i2s_dac_tx
   import i2s_pkg::*;
#(
   parameter int unsigned SAMPLE_W  = 16,
   parameter int unsigned BCLK_HALF = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [SAMPLE_W-1:0] s_left,
   input  logic [SAMPLE_W-1:0] s_right,
   input  logic                s_valid,
   output logic                s_ready,
   output logic                underrun,
   output logic                aud_bclk,
   output logic                aud_daclrck,
   output logic                aud_dacdat
);

   localparam int unsigned PAD_W = SLOT_BITS - 1 - SAMPLE_W;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] left;
      logic signed [SAMPLE_W-1:0] right;
   } pair_t;

   logic                  w_fall_c;
   logic                  w_frame_start_c;
   logic [BIT_CNT_W-1:0]  w_bit_cnt;
   logic [BIT_CNT_W-1:0]  w_bit_nxt;
   logic [SLOT_IDX_W-1:0] w_slot_idx;
   logic [SAMPLE_W-1:0]   w_sample;
   logic [SLOT_BITS-1:0]  w_slot;
   logic                  w_xfer;
   logic                  w_hold_full_nxt;

   pair_t r_hold;
   pair_t r_frame;
   logic  r_hold_full;
   logic  r_s_ready;
   logic  r_underrun;
   logic  r_lrck;
   logic  r_dat;

   i2s_clk_gen #(
      .BCLK_HALF (BCLK_HALF)
   ) u_clk_gen (
      .clk             (clk),
      .reset_n         (reset_n),
      .o_bclk          (aud_bclk),
      .o_fall_c        (w_fall_c),
      .o_frame_start_c (w_frame_start_c),
      .o_bit_cnt       (w_bit_cnt)
   );

   // Holding-register occupancy and the slot bit selected for the next fall.
   always_comb begin
      w_xfer          = s_valid & r_s_ready;
      w_hold_full_nxt = r_hold_full;
      if (w_frame_start_c) w_hold_full_nxt = 1'b0;
      if (w_xfer)          w_hold_full_nxt = 1'b1;

      w_bit_nxt  = w_bit_cnt + BIT_CNT_W'(1);
      w_slot_idx = w_bit_nxt[SLOT_IDX_W-1:0];
      w_sample   = w_bit_nxt[BIT_CNT_W-1] ? r_frame.right : r_frame.left;
      // Slot image MSB-first: bit 31 is the idle slot-0 bit, sample follows, zero pad after.
      w_slot     = SLOT_BITS'(w_sample) << PAD_W;
   end

   // Holding/frame registers, underrun flag and pin outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hold      <= '0;
         r_frame     <= '0;
         r_hold_full <= 1'b0;
         r_s_ready   <= 1'b1;
         r_underrun  <= 1'b0;
         r_lrck      <= 1'b0;
         r_dat       <= 1'b0;
      end else begin
         r_hold_full <= w_hold_full_nxt;
         r_s_ready   <= ~w_hold_full_nxt;
         r_underrun  <= w_frame_start_c & ~r_hold_full;
         if (w_xfer) begin
            r_hold.left  <= s_left;
            r_hold.right <= s_right;
         end
         // A pair arriving on the load cycle itself only lands in the holding register.
         if (w_frame_start_c) begin
            r_frame <= r_hold_full ? r_hold : '0;
         end
         if (w_fall_c) begin
            r_lrck <= w_bit_nxt[BIT_CNT_W-1];
            // Bit at slot index k lives at w_slot[31-k], which is ~k for a 5-bit index.
            r_dat  <= w_slot[~w_slot_idx];
         end
      end
   end

   assign s_ready     = r_s_ready;
   assign underrun    = r_underrun;
   assign aud_daclrck = r_lrck;
   assign aud_dacdat  = r_dat;

endmodule
